// File: rtl/jts16_obj_buf_pkg.sv
// Shared constants and types for the object line buffer: pixel word layout,
// erase value and the readout state encoding.
package jts16_obj_buf_pkg;

    localparam int          OBJ_AW    = 9;
    localparam int          OBJ_DW    = 12;
    localparam logic [11:0] OBJ_ERASE = 12'hFFF;

    // Pixel word layout {prio[1:0], pal[5:0], pxl[3:0]}, shared with draw stage and mixer
    localparam int PRIO_MSB = 11;
    localparam int PAL_MSB  = 9;
    localparam int PXL_MSB  = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RD   = 1'b1
    } rd_st_t;

endpackage

// File: rtl/jtframe_dual_ram.sv
// Two-port RAM: port A write-only, port B registered read plus write.
// A same-address read on port B returns the data from before that edge's write.
module jtframe_dual_ram #(
    parameter int DW = 12,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] data_a,
    input  logic          we_b,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] data_b,
    output logic [DW-1:0] q_b
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Port A is written last so it wins if both ports ever hit the same word
    always_ff @(posedge clk) begin
        q_b <= mem[addr_b];
        if (we_b) mem[addr_b] <= data_b;
        if (we_a) mem[addr_a] <= data_a;
    end

endmodule

// File: rtl/jts16_obj_buf.sv
// Double-buffered object line buffer: the draw stage fills the bank selected
// by line while the bank selected by ~line is read out and erased behind the read.
module jts16_obj_buf
  import jts16_obj_buf_pkg::*;
#(
  parameter int             AW    = OBJ_AW,
  parameter int             DW    = OBJ_DW,
  parameter logic [DW-1:0]  ERASE = OBJ_ERASE
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          pxl_cen,
  input  logic          flip,
  input  logic          line,
  input  logic [AW-1:0] hdump,
  input  logic [DW-1:0] bf_data,
  input  logic          bf_we,
  input  logic [AW-1:0] bf_addr,
  output logic [DW-1:0] pxl
);

  rd_st_t        st_q, st_d;
  logic [AW:0]   rd_addr_q, rd_addr_d;
  logic          ld_q, ld_d;
  logic [DW-1:0] pxl_q, pxl_d;

  logic [AW:0]   wr_addr;
  logic          erase_we;
  logic [DW-1:0] ram_q;

  assign wr_addr = {line, bf_addr};
  assign pxl     = pxl_q;

  always_comb begin
    st_d      = st_q;
    rd_addr_d = rd_addr_q;
    ld_d      = 1'b0;
    pxl_d     = pxl_q;
    erase_we  = 1'b0;
    case (st_q)
      ST_IDLE: begin
        if (pxl_cen) begin
          rd_addr_d = {~line, flip ? ~hdump : hdump};
          st_d      = ST_RD;
        end
      end
      ST_RD: begin
        // RAM word is captured this edge; erase unless a fresh draw write
        // lands on the same word right after a line toggle
        ld_d     = 1'b1;
        erase_we = !(bf_we && (wr_addr == rd_addr_q));
        st_d     = ST_IDLE;
      end
    endcase
    if (ld_q) pxl_d = ram_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q      <= ST_IDLE;
      rd_addr_q <= '0;
      ld_q      <= 1'b0;
      pxl_q     <= ERASE;
    end else begin
      st_q      <= st_d;
      rd_addr_q <= rd_addr_d;
      ld_q      <= ld_d;
      pxl_q     <= pxl_d;
    end
  end

  jtframe_dual_ram #(
    .DW (DW),
    .AW (AW+1)
  ) u_ram (
    .clk    (clk),
    .we_a   (bf_we),
    .addr_a (wr_addr),
    .data_a (bf_data),
    .we_b   (erase_we),
    .addr_b (rd_addr_q),
    .data_b (ERASE),
    .q_b    (ram_q)
  );

endmodule

// File: tb/tb_jts16_obj_buf.sv
// Bench for jts16_obj_buf: directed line-buffer scenarios plus a randomised
// write/readout pass checked against a small bank model.
module tb_jts16_obj_buf;
    import jts16_obj_buf_pkg::*;

    logic        rst, clk, pxl_cen, flip, line, bf_we;
    logic [8:0]  hdump, bf_addr;
    logic [11:0] bf_data, pxl;

    int n_pass  = 0;
    int n_total = 0;
    logic [11:0] exp_q[$];
    logic [11:0] ref_mem [0:511];
    logic [11:0] got, want;

    jts16_obj_buf dut (
        .rst     (rst),
        .clk     (clk),
        .pxl_cen (pxl_cen),
        .flip    (flip),
        .line    (line),
        .hdump   (hdump),
        .bf_data (bf_data),
        .bf_we   (bf_we),
        .bf_addr (bf_addr),
        .pxl     (pxl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [8:0] a, input logic [11:0] d);
        bf_we = 1'b1; bf_addr = a; bf_data = d;
        tick;
        bf_we = 1'b0;
    endtask

    // Issue one readout, wait for the result to land on pxl, return it with
    // the expectation popped from the scoreboard
    task automatic do_read(input logic [8:0] h, input logic [11:0] e,
                           output logic [11:0] g, output logic [11:0] w);
        hdump = h; pxl_cen = 1'b1;
        exp_q.push_back(e);
        tick;
        pxl_cen = 1'b0;
        tick;
        tick;
        g = pxl;
        w = exp_q.pop_front();
    endtask

    task automatic clear_all;
        for (int b = 0; b < 2; b++) begin
            line = b[0];
            for (int a = 0; a < 512; a++) begin
                hdump = a[8:0]; pxl_cen = 1'b1;
                tick;
                pxl_cen = 1'b0;
                tick;
            end
        end
        tick;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (pxl !== 12'hFFF) $display("FAIL reset_pxl: got %h want fff", pxl); else n_pass++;
        n_total++;
        if (dut.st_q !== ST_IDLE) $display("FAIL reset_state: got %0d want IDLE", dut.st_q); else n_pass++;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid_read;
        line = 1'b0;
        wr(9'd30, 12'h7E2);
        wr(9'd31, 12'h6D1);
        line = 1'b1;
        do_read(9'd31, 12'h6D1, got, want);
        n_total++;
        if (got !== want) $display("FAIL pre_reset_read: got %h want %h", got, want); else n_pass++;
        hdump = 9'd30; pxl_cen = 1'b1;
        tick;
        pxl_cen = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if (pxl !== 12'hFFF) $display("FAIL midrd_reset_pxl: got %h want fff", pxl); else n_pass++;
        n_total++;
        if (dut.st_q !== ST_IDLE) $display("FAIL midrd_reset_state: got %0d want IDLE", dut.st_q); else n_pass++;
        tick;
        rst = 1'b0;
        tick;
        do_read(9'd30, 12'h7E2, got, want);
        n_total++;
        if (got !== want) $display("FAIL midrd_no_erase: got %h want %h", got, want); else n_pass++;
    endtask

    task automatic test_basic_line;
        line = 1'b0;
        wr(9'd20, 12'h5A3);
        line = 1'b1;
        do_read(9'd20, 12'h5A3, got, want);
        n_total++;
        if (got !== want) $display("FAIL basic_read: got %h want %h", got, want); else n_pass++;
        do_read(9'd20, 12'hFFF, got, want);
        n_total++;
        if (got !== want) $display("FAIL basic_erased: got %h want %h", got, want); else n_pass++;
    endtask

    task automatic test_overwrite;
        line = 1'b0;
        wr(9'd100, 12'h111);
        wr(9'd100, 12'h222);
        line = 1'b1;
        do_read(9'd100, 12'h222, got, want);
        n_total++;
        if (got !== want) $display("FAIL overwrite: got %h want %h", got, want); else n_pass++;
    endtask

    task automatic test_flip;
        line = 1'b0; flip = 1'b1;
        wr(9'd0, 12'h3C7);
        line = 1'b1;
        do_read(9'h1FF, 12'h3C7, got, want);
        n_total++;
        if (got !== want) $display("FAIL flip_mirror: got %h want %h", got, want); else n_pass++;
        do_read(9'd0, 12'hFFF, got, want);
        n_total++;
        if (got !== want) $display("FAIL flip_zero: got %h want %h", got, want); else n_pass++;
        flip = 1'b0;
    endtask

    task automatic test_bank_isolation;
        line = 1'b0;
        wr(9'd50, 12'h0B5);
        line = 1'b1;
        hdump = 9'd50; pxl_cen = 1'b1;
        bf_we = 1'b1; bf_addr = 9'd50; bf_data = 12'h0C6;
        exp_q.push_back(12'h0B5);
        tick;
        pxl_cen = 1'b0; bf_we = 1'b0;
        tick;
        tick;
        got = pxl; want = exp_q.pop_front();
        n_total++;
        if (got !== want) $display("FAIL iso_read_bank0: got %h want %h", got, want); else n_pass++;
        line = 1'b0;
        do_read(9'd50, 12'h0C6, got, want);
        n_total++;
        if (got !== want) $display("FAIL iso_bank1_kept: got %h want %h", got, want); else n_pass++;
        line = 1'b1;
        do_read(9'd50, 12'hFFF, got, want);
        n_total++;
        if (got !== want) $display("FAIL iso_bank0_erased: got %h want %h", got, want); else n_pass++;
    endtask

    task automatic test_swap_collision;
        line = 1'b0;
        wr(9'd7, 12'h0D4);
        line = 1'b1;
        hdump = 9'd7; pxl_cen = 1'b1;
        exp_q.push_back(12'h0D4);
        tick;
        pxl_cen = 1'b0;
        line = 1'b0;
        bf_we = 1'b1; bf_addr = 9'd7; bf_data = 12'h0A1;
        tick;
        bf_we = 1'b0;
        tick;
        got = pxl; want = exp_q.pop_front();
        n_total++;
        if (got !== want) $display("FAIL swap_old_read: got %h want %h", got, want); else n_pass++;
        line = 1'b1;
        do_read(9'd7, 12'h0A1, got, want);
        n_total++;
        if (got !== want) $display("FAIL swap_write_wins: got %h want %h", got, want); else n_pass++;
        do_read(9'd7, 12'hFFF, got, want);
        n_total++;
        if (got !== want) $display("FAIL swap_erased: got %h want %h", got, want); else n_pass++;
    endtask

    task automatic test_random;
        logic [8:0]  a, h;
        logic [11:0] d;
        logic        f;
        for (int i = 0; i < 512; i++) ref_mem[i] = 12'hFFF;
        line = 1'b0;
        for (int i = 0; i < 24; i++) begin
            a = 9'(200 + $urandom_range(0, 15));
            d = 12'($urandom_range(0, 12'hFFE));
            wr(a, d);
            ref_mem[a] = d;
        end
        line = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a = 9'(200 + i);
            f = 1'($urandom_range(0, 1));
            flip = f;
            h = f ? ~a : a;
            do_read(h, ref_mem[a], got, want);
            ref_mem[a] = 12'hFFF;
            n_total++;
            if (got !== want) $display("FAIL rand_read addr=%0d flip=%0d: got %h want %h", a, f, got, want); else n_pass++;
        end
        flip = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pxl_cen = 1'b0; flip = 1'b0; line = 1'b0;
        hdump = '0; bf_data = '0; bf_we = 1'b0; bf_addr = '0;
        test_reset;
        test_reset_mid_read;
        clear_all;
        test_basic_line;
        test_overwrite;
        test_flip;
        test_bank_isolation;
        test_swap_collision;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
